// File: rtl/dummy_source_if.sv
// AXI4-Stream bundle between dummy_source and its downstream sink.
interface dummy_source_if #(
    parameter int unsigned DataWidth = 64
);
    logic                   tvalid;
    logic                   tready;
    logic [DataWidth-1:0]   tdata;
    logic [DataWidth/8-1:0] tstrb;
    logic                   tlast;

    modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/dummy_source.sv
// AXI4-Stream traffic generator: emits framed packets whose beats carry
// {packet index, beat index}, honouring backpressure and a graceful stop.
module dummy_source #(
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int unsigned C_PKT_LEN_WIDTH        = 16,
    parameter int unsigned C_PKT_CNT_WIDTH        = 16
) (
    input  logic                       m00_axis_aclk,
    input  logic                       m00_axis_aresetn,
    input  logic                       start,
    input  logic                       stop,
    input  logic [C_PKT_LEN_WIDTH-1:0] pkt_len,
    input  logic [C_PKT_CNT_WIDTH-1:0] num_pkts,
    dummy_source_if.master             m00_axis,
    output logic                       busy,
    output logic                       done,
    output logic [C_PKT_CNT_WIDTH-1:0] pkts_sent
);

    localparam int unsigned HalfWidth = C_M00_AXIS_TDATA_WIDTH / 2;
    localparam int unsigned StrbWidth = C_M00_AXIS_TDATA_WIDTH / 8;
    localparam logic [C_PKT_LEN_WIDTH-1:0] LenOne = 1;
    localparam logic [C_PKT_CNT_WIDTH-1:0] CntOne = 1;

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e                      state_q, state_d;
    logic [C_PKT_LEN_WIDTH-1:0]  pkt_len_q, pkt_len_d;
    logic [C_PKT_CNT_WIDTH-1:0]  num_pkts_q, num_pkts_d;
    logic [C_PKT_LEN_WIDTH-1:0]  beat_idx_q, beat_idx_d;
    logic [C_PKT_CNT_WIDTH-1:0]  pkt_idx_q, pkt_idx_d;
    logic                        done_q, done_d;
    logic                        stop_pend_q, stop_pend_d;
    logic                        tvalid_q, tlast_q, busy_q;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_q;

    logic                 hs;
    logic                 send_d;
    logic                 last_d;
    logic [HalfWidth-1:0] pkt_field;
    logic [HalfWidth-1:0] beat_field;

    assign hs = tvalid_q & m00_axis.tready;

    always_comb begin
        state_d     = state_q;
        pkt_len_d   = pkt_len_q;
        num_pkts_d  = num_pkts_q;
        beat_idx_d  = beat_idx_q;
        pkt_idx_d   = pkt_idx_q;
        done_d      = done_q;
        stop_pend_d = stop_pend_q;
        unique case (state_q)
            StIdle: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    pkt_len_d  = (pkt_len == '0) ? LenOne : pkt_len;
                    num_pkts_d = num_pkts;
                    beat_idx_d = '0;
                    pkt_idx_d  = '0;
                    done_d     = 1'b0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (hs) begin
                    // tlast_q already encodes "current beat is the packet's last"
                    if (tlast_q) begin
                        beat_idx_d = '0;
                        pkt_idx_d  = pkt_idx_q + CntOne;
                        if ((num_pkts_q != '0 && pkt_idx_d == num_pkts_q) || stop_pend_q || stop) begin
                            state_d     = StDone;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + LenOne;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign send_d = (state_d == StSend);
    assign last_d = send_d && (beat_idx_d == pkt_len_d - LenOne);

    // Fit each index into its half of tdata: zero-extend if narrower, truncate if wider.
    if (C_PKT_CNT_WIDTH >= HalfWidth) begin : g_pkt_trunc
        assign pkt_field = pkt_idx_d[HalfWidth-1:0];
    end else begin : g_pkt_ext
        assign pkt_field = {{(HalfWidth - C_PKT_CNT_WIDTH){1'b0}}, pkt_idx_d};
    end

    if (C_PKT_LEN_WIDTH >= HalfWidth) begin : g_beat_trunc
        assign beat_field = beat_idx_d[HalfWidth-1:0];
    end else begin : g_beat_ext
        assign beat_field = {{(HalfWidth - C_PKT_LEN_WIDTH){1'b0}}, beat_idx_d};
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            state_q     <= StIdle;
            pkt_len_q   <= '0;
            num_pkts_q  <= '0;
            beat_idx_q  <= '0;
            pkt_idx_q   <= '0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_len_q   <= pkt_len_d;
            num_pkts_q  <= num_pkts_d;
            beat_idx_q  <= beat_idx_d;
            pkt_idx_q   <= pkt_idx_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
            tvalid_q    <= send_d;
            tdata_q     <= send_d ? {pkt_field, beat_field} : '0;
            tlast_q     <= last_d;
            busy_q      <= send_d;
        end
    end

    assign m00_axis.tvalid = tvalid_q;
    assign m00_axis.tdata  = tdata_q;
    assign m00_axis.tstrb  = {StrbWidth{tvalid_q}};
    assign m00_axis.tlast  = tlast_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pkts_sent       = pkt_idx_q;

endmodule

// File: tb/tb_dummy_source.sv
// Bench for dummy_source: table of runs plus randomized runs, each checked beat by beat
// against an expected-beat queue built from packet length and count.
module tb_dummy_source;

    localparam int unsigned W = 64;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int len;
        int npk;
        int mode;       // 0: tready=1, 1: fixed 1,0,0,1,0,1 pattern, 2: random
        int stop_pkt;   // packet whose beat 0 gets a stop pulse; -1 for none
        int exp_sent;
        int exp_beats;
    } case_t;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        start;
    logic        stop;
    logic [15:0] pkt_len;
    logic [15:0] num_pkts;
    logic        busy;
    logic        done;
    logic [15:0] pkts_sent;

    beat_t exp_q[$];
    int    passed = 0;
    int    total  = 0;
    case_t tbl[7];
    case_t rc;

    dummy_source_if #(.DataWidth(W)) axis ();

    dummy_source #(
        .C_M00_AXIS_TDATA_WIDTH(W),
        .C_PKT_LEN_WIDTH       (16),
        .C_PKT_CNT_WIDTH       (16)
    ) dut (
        .m00_axis_aclk   (clk),
        .m00_axis_aresetn(aresetn),
        .start           (start),
        .stop            (stop),
        .pkt_len         (pkt_len),
        .num_pkts        (num_pkts),
        .m00_axis        (axis),
        .busy            (busy),
        .done            (done),
        .pkts_sent       (pkts_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(axis.tvalid === 1'b0, {tag, "_tvalid"}, axis.tvalid, 0);
        chk(axis.tdata === 64'd0, {tag, "_tdata"}, axis.tdata, 0);
        chk(axis.tstrb === 8'h00, {tag, "_tstrb"}, axis.tstrb, 0);
        chk(axis.tlast === 1'b0, {tag, "_tlast"}, axis.tlast, 0);
        chk(busy === 1'b0 && done === 1'b0, {tag, "_busy_done"}, {busy, done}, 0);
        chk(pkts_sent === 16'd0, {tag, "_pkts_sent"}, pkts_sent, 0);
    endtask

    task automatic run_case(input case_t c);
        int          eff, np, cyc, nxfer;
        bit          finished, v, hs, prev_stall, stop_sent, l, prev_l;
        logic [63:0] d, prev_d;
        logic [5:0]  pat;
        pat = 6'b101001;
        eff = (c.len == 0) ? 1 : c.len;
        np  = (c.npk == 0) ? c.stop_pkt + 1 : c.npk;
        exp_q.delete();
        for (int p = 0; p < np; p++)
            for (int b = 0; b < eff; b++)
                exp_q.push_back('{data: {32'(p), 32'(b)}, last: (b == eff - 1)});

        @(negedge clk);
        pkt_len     = 16'(c.len);
        num_pkts    = 16'(c.npk);
        start       = 1'b1;
        stop        = (c.stop_pkt < 0);  // stop while idle must be ignored
        axis.tready = 1'b0;
        @(negedge clk);
        chk(axis.tvalid === 1'b1, "valid_latency", axis.tvalid, 1);
        chk(done === 1'b0, "done_cleared", done, 0);

        cyc = 0; nxfer = 0; finished = 0; prev_stall = 0; stop_sent = 0;
        prev_d = '0; prev_l = 0;
        while (!finished && cyc < 2000) begin
            v = axis.tvalid; d = axis.tdata; l = axis.tlast;
            case (c.mode)
                0:       axis.tready = 1'b1;
                1:       axis.tready = pat[cyc % 6];
                default: axis.tready = 1'($urandom_range(0, 1));
            endcase
            // mid-run start and parameter changes must have no effect
            start    = 1'($urandom_range(0, 1));
            pkt_len  = 16'($urandom);
            num_pkts = 16'($urandom);
            stop     = 1'b0;
            if (c.stop_pkt >= 0 && !stop_sent && v && d == {32'(c.stop_pkt), 32'd0}) begin
                stop      = 1'b1;
                stop_sent = 1;
            end
            hs = v & axis.tready;
            chk(v, "valid_held", v, 1);
            if (!v) break;
            if (prev_stall)
                chk(d === prev_d && l === prev_l, "stall_stable", d, prev_d);
            chk(d === exp_q[0].data, "tdata", d, exp_q[0].data);
            chk(l === exp_q[0].last, "tlast", l, exp_q[0].last);
            chk(axis.tstrb === 8'hFF, "tstrb", axis.tstrb, 8'hFF);
            if (hs) begin
                void'(exp_q.pop_front());
                nxfer++;
                finished = (exp_q.size() == 0);
            end
            prev_stall = v & ~axis.tready;
            prev_d = d; prev_l = l;
            cyc++;
            if (!finished) @(negedge clk);
        end
        chk(finished, "run_completes", nxfer, c.exp_beats);

        @(negedge clk);
        start = 1'b0;
        stop  = 1'b1;  // stop during DONE must be ignored
        axis.tready = 1'b1;
        chk(axis.tvalid === 1'b0, "valid_after_run", axis.tvalid, 0);
        chk(done === 1'b1, "done_set", done, 1);
        chk(busy === 1'b0, "busy_after_run", busy, 0);
        chk(pkts_sent === 16'(c.exp_sent), "pkts_sent", pkts_sent, 64'(c.exp_sent));
        chk(nxfer == c.exp_beats, "beat_count", nxfer, 64'(c.exp_beats));
        @(negedge clk);
        stop = 1'b0;
        chk(done === 1'b1 && axis.tvalid === 1'b0, "done_sticky", {done, axis.tvalid}, 2'b10);
    endtask

    initial begin
        tbl = '{
            '{len: 4, npk: 2, mode: 0, stop_pkt: -1, exp_sent: 2, exp_beats: 8},
            '{len: 3, npk: 1, mode: 1, stop_pkt: -1, exp_sent: 1, exp_beats: 3},
            '{len: 0, npk: 3, mode: 0, stop_pkt: -1, exp_sent: 3, exp_beats: 3},
            '{len: 2, npk: 0, mode: 0, stop_pkt: 5,  exp_sent: 6, exp_beats: 12},
            '{len: 1, npk: 0, mode: 0, stop_pkt: 2,  exp_sent: 3, exp_beats: 3},
            '{len: 5, npk: 3, mode: 2, stop_pkt: -1, exp_sent: 3, exp_beats: 15},
            '{len: 2, npk: 0, mode: 2, stop_pkt: 1,  exp_sent: 2, exp_beats: 4}
        };

        aresetn = 1'b0; start = 1'b0; stop = 1'b0;
        pkt_len = '0; num_pkts = '0; axis.tready = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        aresetn = 1'b1;

        for (int i = 0; i < 7; i++) run_case(tbl[i]);

        // Reset in the middle of a packet, with a handshake pending.
        @(negedge clk);
        pkt_len = 16'd8; num_pkts = 16'd1; start = 1'b1; axis.tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && !(axis.tvalid === 1'b1 && axis.tdata === 64'd3); k++)
            @(negedge clk);
        chk(axis.tdata === 64'd3, "reach_beat3", axis.tdata, 3);
        aresetn = 1'b0;
        @(negedge clk);
        chk_all_zero("midrun_reset");
        aresetn = 1'b1;
        run_case('{len: 8, npk: 1, mode: 0, stop_pkt: -1, exp_sent: 1, exp_beats: 8});

        for (int i = 0; i < 8; i++) begin
            rc.len  = $urandom_range(0, 6);
            rc.mode = 2;
            if (i % 4 == 3) begin
                rc.npk      = 0;
                rc.stop_pkt = $urandom_range(0, 3);
                rc.exp_sent = rc.stop_pkt + 1;
            end else begin
                rc.npk      = $urandom_range(1, 4);
                rc.stop_pkt = -1;
                rc.exp_sent = rc.npk;
            end
            rc.exp_beats = rc.exp_sent * ((rc.len == 0) ? 1 : rc.len);
            run_case(rc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
